// File: rtl/wishbone_queue_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_queue_pkg
// Shared types and sizing helpers for the Wishbone command/response queue.
//   cmd_entry_t : one queued command {write_en, data} at the default width
//   rsp_entry_t : one queued response {is_write, data} at the default width
//   ptr_w()     : pointer/count width for a power-of-two FIFO depth
//   addr_w()    : storage index width for a FIFO depth
// Optional feature macro used by the queue: WB_CMD_QUEUE_WRITE_RSP_EN.
// -----------------------------------------------------------------------------
package wishbone_queue_pkg;

  localparam int WB_DAT_W = 8;

  typedef struct packed {
    logic                write_en;
    logic [WB_DAT_W-1:0] data;
  } cmd_entry_t;

  typedef struct packed {
    logic                is_write;
    logic [WB_DAT_W-1:0] data;
  } rsp_entry_t;

  // One extra MSB distinguishes full from empty when the index bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Generic single-clock FIFO with occupancy count. A push is accepted when the
// FIFO is not full, or when it is full and a pop happens on the same edge.
// Storage is not reset; only the pointers are.
// Ports:
//   clk_i    in  clock
//   rst_ni   in  asynchronous active-low reset (pointers only)
//   i_push   in  write request
//   i_data   in  write data
//   i_pop    in  read request (ignored when empty)
//   o_data   out oldest entry (meaningless when empty)
//   o_empty  out FIFO holds no entries
//   o_count  out number of stored entries
// -----------------------------------------------------------------------------
module sync_fifo
  import wishbone_queue_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic [ptr_w(DEPTH)-1:0]    o_count
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/wishbone_ctrl_cmd_queue.sv
// -----------------------------------------------------------------------------
// wishbone_ctrl_cmd_queue
// Command/response buffer in front of the Wishbone classic cycle controller.
// Commands enter on a valid/ready port, the oldest is presented to the
// controller, and it retires when the controller latches it. Read data
// returned on ack is stored in a response queue.
// Optional feature macro: WB_CMD_QUEUE_WRITE_RSP_EN -- writes also produce a
// response {rsp_is_write=1, rsp_data=0} and need response space to issue.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cmd_valid/ready            command handshake
//   cmd_write_en, cmd_data     command type and write data
//   rsp_valid/ready, rsp_data  response handshake and read data
//   rsp_is_write               response kind (feature build only)
//   start, write_en, write_data  head command offered to the controller
//   cyc, ack, read_data        controller cycle status and returned data
// -----------------------------------------------------------------------------
module wishbone_ctrl_cmd_queue
  import wishbone_queue_pkg::*;
#(
  parameter int DAT_WIDTH = WB_DAT_W,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write_en,
  input  logic [DAT_WIDTH-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DAT_WIDTH-1:0] rsp_data,
`ifdef WB_CMD_QUEUE_WRITE_RSP_EN
  output logic                 rsp_is_write,
`endif
  output logic                 start,
  output logic                 write_en,
  output logic [DAT_WIDTH-1:0] write_data,
  input  logic                 cyc,
  input  logic                 ack,
  input  logic [DAT_WIDTH-1:0] read_data
);

  localparam int CPW = ptr_w(CMD_DEPTH);
  localparam int RPW = ptr_w(RSP_DEPTH);
  localparam logic [CPW-1:0] CMD_LIM = CMD_DEPTH[CPW-1:0];
  localparam logic [RPW:0]   RSP_LIM = RSP_DEPTH[RPW:0];
`ifdef WB_CMD_QUEUE_WRITE_RSP_EN
  localparam int RSP_W = DAT_WIDTH + 1;
`else
  localparam int RSP_W = DAT_WIDTH;
`endif

  logic [DAT_WIDTH:0] w_cmd_head;
  logic               w_cmd_empty;
  logic [CPW-1:0]     w_cmd_count;
  logic               w_cmd_push;
  logic [RSP_W-1:0]   w_rsp_head;
  logic [RSP_W-1:0]   w_rsp_wdata;
  logic               w_rsp_empty;
  logic [RPW-1:0]     w_rsp_count;
  logic               w_rsp_push;
  logic               w_rsp_pop;
  logic               w_reserved;
  logic [RPW:0]       w_rsp_used;
  logic               w_rsp_room;
  logic               w_issue_ok;
  logic               w_latch;

  // ---- command queue: accept, hold head for the controller ----
  assign cmd_ready  = (w_cmd_count != CMD_LIM);
  assign w_cmd_push = cmd_valid && cmd_ready;

  sync_fifo #(
    .WIDTH (DAT_WIDTH + 1),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_cmd_push),
    .i_data  ({cmd_write_en, cmd_data}),
    .i_pop   (w_latch),
    .o_data  (w_cmd_head),
    .o_empty (w_cmd_empty),
    .o_count (w_cmd_count)
  );

  // A read in flight owns one response slot until its ack arrives, so the
  // response queue can never overflow.
  assign w_rsp_used = {1'b0, w_rsp_count} + {{RPW{1'b0}}, w_reserved};
  assign w_rsp_room = (w_rsp_used < RSP_LIM);

  assign start      = !w_cmd_empty && w_issue_ok;
  assign write_en   = w_cmd_empty ? 1'b0 : w_cmd_head[DAT_WIDTH];
  assign write_data = w_cmd_empty ? '0 : w_cmd_head[DAT_WIDTH-1:0];

  // Mirrors the controller's own latch condition: idle, or finishing now.
  assign w_latch    = start && (!cyc || ack);

  // ---- in-flight tracking and response capture ----
`ifdef WB_CMD_QUEUE_WRITE_RSP_EN
  logic r_inflight;
  logic r_inflight_wr;

  assign w_reserved  = r_inflight;
  assign w_issue_ok  = w_rsp_room;
  assign w_rsp_push  = ack && r_inflight;
  assign w_rsp_wdata = {r_inflight_wr, r_inflight_wr ? {DAT_WIDTH{1'b0}} : read_data};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight    <= 1'b0;
      r_inflight_wr <= 1'b0;
    end else if (w_latch) begin
      r_inflight    <= 1'b1;
      r_inflight_wr <= write_en;
    end else if (ack) begin
      r_inflight    <= 1'b0;
    end
  end

  assign rsp_is_write = !w_rsp_empty && w_rsp_head[DAT_WIDTH];
`else
  logic r_rd_inflight;

  assign w_reserved  = r_rd_inflight;
  assign w_issue_ok  = write_en || w_rsp_room;
  assign w_rsp_push  = ack && r_rd_inflight;
  assign w_rsp_wdata = read_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_inflight <= 1'b0;
    end else if (w_latch) begin
      r_rd_inflight <= !write_en;
    end else if (ack) begin
      r_rd_inflight <= 1'b0;
    end
  end
`endif

  // ---- response queue ----
  assign rsp_valid = !w_rsp_empty;
  assign w_rsp_pop = rsp_valid && rsp_ready;
  assign rsp_data  = w_rsp_empty ? '0 : w_rsp_head[DAT_WIDTH-1:0];

  sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_rsp_push),
    .i_data  (w_rsp_wdata),
    .i_pop   (w_rsp_pop),
    .o_data  (w_rsp_head),
    .o_empty (w_rsp_empty),
    .o_count (w_rsp_count)
  );

endmodule

// File: tb/tb_wishbone_ctrl_cmd_queue.sv
`timescale 1ns/1ps
module tb_wishbone_ctrl_cmd_queue;
  import wishbone_queue_pkg::*;

  localparam int CD = 4;
  localparam int RD = 4;
`ifdef WB_CMD_QUEUE_WRITE_RSP_EN
  localparam bit WRSP = 1'b1;
`else
  localparam bit WRSP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       cmd_valid, cmd_ready, cmd_write_en;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       obs_isw;
  logic       start, write_en;
  logic [7:0] write_data;
  logic       cyc, ack;
  logic [7:0] read_data;

  always #5 clk = ~clk;

`ifdef WB_CMD_QUEUE_WRITE_RSP_EN
  logic rsp_is_write;
  assign obs_isw = rsp_is_write;
`else
  assign obs_isw = 1'b0;
`endif

  wishbone_ctrl_cmd_queue #(.DAT_WIDTH(8), .CMD_DEPTH(CD), .RSP_DEPTH(RD)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write_en (cmd_write_en),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
`ifdef WB_CMD_QUEUE_WRITE_RSP_EN
    .rsp_is_write (rsp_is_write),
`endif
    .start        (start),
    .write_en     (write_en),
    .write_data   (write_data),
    .cyc          (cyc),
    .ack          (ack),
    .read_data    (read_data)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain queues plus a behavioural Wishbone controller.
  cmd_entry_t m_cmdq[$];
  rsp_entry_t m_rspq[$];
  rsp_entry_t popped[$];
  logic [7:0] rd_fixed[$];
  logic       ctl_busy = 1'b0;
  cmd_entry_t ctl_cmd;
  int         ctl_wait = 0;
  int         max_wait = 0;
  int         n_acks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_start();
    int  reserve;
    logic need;
    if (m_cmdq.size() == 0) return 1'b0;
    need    = WRSP ? 1'b1 : !m_cmdq[0].write_en;
    reserve = (ctl_busy && (WRSP || !ctl_cmd.write_en)) ? 1 : 0;
    return !need || ((m_rspq.size() + reserve) < RD);
  endfunction

  // One clock: check outputs, drive inputs at negedge, advance the model
  // across the next rising edge, return just after it.
  task automatic cycle(input logic pv, input logic pwe, input logic [7:0] pd,
                       input logic pr, input logic stray, output logic acc);
    logic st, lat, ak, done;
    logic [7:0] rdv;
    @(negedge clk);
    st = exp_start();
    chk("start", start, st);
    chk("cmd_ready", cmd_ready, m_cmdq.size() < CD);
    chk("rsp_valid", rsp_valid, m_rspq.size() > 0);
    chk("write_en", write_en, (m_cmdq.size() > 0) ? m_cmdq[0].write_en : 1'b0);
    chk("write_data", write_data, (m_cmdq.size() > 0) ? m_cmdq[0].data : 8'h00);
    chk("rsp_data", rsp_data, (m_rspq.size() > 0) ? m_rspq[0].data : 8'h00);
    if (WRSP) chk("rsp_is_write", obs_isw, (m_rspq.size() > 0) ? m_rspq[0].is_write : 1'b0);
    if (pr && rsp_valid) popped.push_back('{is_write: obs_isw, data: rsp_data});

    done = ctl_busy && (ctl_wait == 0);
    ak   = done || (stray && !ctl_busy);
    rdv  = 8'($urandom);
    if (done && !ctl_cmd.write_en && rd_fixed.size() > 0) rdv = rd_fixed.pop_front();
    cmd_valid = pv; cmd_write_en = pwe; cmd_data = pd; rsp_ready = pr;
    cyc = ctl_busy; ack = ak; read_data = rdv;

    lat = st && (!ctl_busy || ak);
    acc = pv && (m_cmdq.size() < CD);
    if (pr && m_rspq.size() > 0) void'(m_rspq.pop_front());
    if (done) begin
      n_acks++;
      if (!ctl_cmd.write_en) m_rspq.push_back('{is_write: 1'b0, data: rdv});
      else if (WRSP)         m_rspq.push_back('{is_write: 1'b1, data: 8'h00});
    end
    if (lat) begin
      ctl_cmd  = m_cmdq.pop_front();
      ctl_busy = 1'b1;
      ctl_wait = $urandom_range(max_wait, 0);
    end else if (done) begin
      ctl_busy = 1'b0;
    end else if (ctl_busy) begin
      ctl_wait--;
    end
    if (acc) m_cmdq.push_back('{write_en: pwe, data: pd});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic pr);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, pr, 1'b0, a);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_start", start, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_write_en", write_en, 1'b0);
    chk("rst_write_data", write_data, 8'h00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    cmd_valid = 1'b0; rsp_ready = 1'b0; cyc = 1'b0; ack = 1'b0;
    m_cmdq.delete(); m_rspq.delete(); rd_fixed.delete();
    ctl_busy = 1'b0; ctl_wait = 0;
    @(posedge clk); #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic a;
    int   acc_n, acks0;
    rst_ni = 1'b0; cmd_valid = 1'b0; cmd_write_en = 1'b0; cmd_data = 8'h00;
    rsp_ready = 1'b0; cyc = 1'b0; ack = 1'b0; read_data = 8'h00;
    do_reset();

    // Single write: visible one clock after push, no response by default.
    max_wait = 0;
    cycle(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, a);
    chk("t2_start", start, 1'b1);
    chk("t2_write_en", write_en, 1'b1);
    chk("t2_write_data", write_data, 8'hA5);
    idle(3, 1'b0);
    chk("t2_rsp_after_write", rsp_valid, WRSP);

    // Three back-to-back reads with known return data.
    idle(2, 1'b1);
    popped.delete();
    rd_fixed = '{8'h11, 8'h22, 8'h33};
    acks0 = n_acks;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, a);
    idle(2, 1'b0);
    chk("t3_acks_back_to_back", n_acks - acks0, 3);
    idle(4, 1'b1);
    chk("t3_rsp_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("t3_rsp0", popped[0].data, 8'h11);
      chk("t3_rsp1", popped[1].data, 8'h22);
      chk("t3_rsp2", popped[2].data, 8'h33);
    end

    // Reset while the controller is busy with a read.
    max_wait = 3;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, a);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, a);
    do_reset();
    idle(2, 1'b0);

    // Six reads against a stalled response queue of depth four.
    max_wait = 0;
    acks0 = n_acks; acc_n = 0;
    for (int i = 0; i < 40 && acc_n < 6; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, a);
      if (a) acc_n++;
    end
    idle(8, 1'b0);
    chk("t4_acks_limited", n_acks - acks0, 4);
    chk("t4_start_blocked", start, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, a);
    idle(4, 1'b0);
    chk("t4_next_read_issued", n_acks - acks0, 5);

    // Fill the command queue while issue is blocked.
    acc_n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0, 1'b0, a);
      if (a) acc_n++;
    end
    chk("t5_accepted", acc_n, 3);
    chk("t5_cmd_ready_full", cmd_ready, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, a);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, a);
    cycle(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, a);
    chk("t5_push_pop_accepted", a, 1'b1);
    chk("t5_count_stays_3", cmd_ready, 1'b1);

    // Ack with nothing latched is ignored.
    idle(10, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, a);
    chk("stray_ack_no_rsp", rsp_valid, 1'b0);

    // Randomized traffic.
    max_wait = 2;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 8'($urandom),
            ($urandom_range(9, 0) < 6), ($urandom_range(15, 0) == 0), a);
    end
    idle(30, 1'b1);

`ifdef WB_CMD_QUEUE_WRITE_RSP_EN
    do_reset();
    max_wait = 1;
    popped.delete();
    rd_fixed = '{8'h77};
    cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, a);
    idle(8, 1'b0);
    idle(3, 1'b1);
    chk("t6_rsp_count", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("t6_rsp0_is_write", popped[0].is_write, 1'b1);
      chk("t6_rsp0_data", popped[0].data, 8'h00);
      chk("t6_rsp1_is_write", popped[1].is_write, 1'b0);
      chk("t6_rsp1_data", popped[1].data, 8'h77);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
